sseg_scan: RTL and testbench
============================

SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000: clock cycles each digit stays enabled; legal range 1..2^20.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port load  input  1  single-cycle strobe that captures value, dp_in and blank_lz.
REQ-005 SHALL have port value  input  16  four hex nibbles; nibble 0 = value[3:0] = rightmost digit.
REQ-006 SHALL have port dp_in  input  4  decimal-point request per digit; bit i = digit i, 1 = lit.
REQ-007 SHALL have port blank_lz  input  1  1 = suppress leading-zero digits.
REQ-008 SHALL have port digit  output  4  nibble for the active digit, fed directly to the hex-to-7-segment decoder.
REQ-009 SHALL have port an  output  4  active-low digit enables; bit i low = digit i lit.
REQ-010 SHALL have port dp  output  1  active-low decimal-point segment for the active digit.
REQ-011 SHALL have port frame  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-012 SHALL hold a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; the terminal count is the "tick".
REQ-013 SHALL hold a 2-bit digit index idx, advancing 0->1->2->3->0 on each tick.
REQ-014 SHALL time-multiplex the digits so that each digit is enabled for exactly REFRESH_DIV cycles and a full frame lasts 4*REFRESH_DIV cycles.
REQ-015 SHALL, with REFRESH_DIV=1, tick on every cycle; idx advances every cycle.
REQ-016 SHALL latch value, dp_in and blank_lz into held registers on the edge where load=1.
REQ-017 SHALL make a load visible on the outputs from the following cycle, at the current idx.
REQ-018 SHALL NOT let a load disturb the prescaler or idx.
REQ-019 SHALL ignore inputs value, dp_in and blank_lz whenever load=0.
REQ-020 SHALL drive digit = held nibble[idx], as a combinational function of registered state only, with no input-to-output path.
REQ-021 SHALL drive an = ~(4'b0001 << idx) unless the active digit is blanked, in which case an = 4'b1111.
REQ-022 SHALL drive dp = ~held_dp[idx] when the active digit is not blanked, and dp = 1 when it is blanked.
REQ-023 SHALL blank the active digit when held blank_lz=1, idx>0, and every held nibble at position >= idx is zero.
REQ-024 SHALL blank using held data only, and SHALL never blank digit 0.
REQ-025 SHALL NOT blank a zero nibble that lies between nonzero nibbles (e.g. 0x1020 shows all four digits).
REQ-026 SHALL assert frame for exactly the one cycle after the tick moves idx from 3 to 0, so frame is registered.
REQ-027 SHALL, when load and tick coincide, apply both: new data at the new idx on the next cycle.
REQ-028 SHALL keep digit and dp free of X for all 16 nibble values, so that every nibble maps to a defined decoder input.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, set prescaler=0, idx=0, held value=0, held dp=0 and held blank_lz=0.
REQ-030 SHALL, during and after reset, drive digit=4'h0, an=4'b1110, dp=1 and frame=0.
REQ-031 SHALL give rst_n priority over load; a load coinciding with reset is discarded.
REQ-032 SHALL restart scanning from digit 0 after rst_n deasserts mid-frame, with a full REFRESH_DIV dwell on digit 0.

Verification (REFRESH_DIV=4 unless stated)
REQ-033 Reset then load value=16'h1234, dp_in=0, blank_lz=0 -> an sequence 1110,1101,1011,0111 every 4 cycles; digit 4,3,2,1; frame pulses once per 16 cycles.
REQ-034 Load 16'h0007, blank_lz=1 -> digit 0 shows 7 with an=1110; digits 1-3 give an=1111 and dp=1. Load 16'h0000, blank_lz=1 -> only digit 0 lit, showing 0.
REQ-035 Load 16'h1020, blank_lz=1, dp_in=4'b0100 -> all four digits lit; dp=0 only while an=1011.
REQ-036 Load pulse on the same edge as the idx 1->2 tick with value=16'hABCD -> next cycle digit=4'hB, an=1011.
REQ-037 Assert rst_n=0 for 1 cycle mid-frame at idx=2 -> next cycle an=1110, digit=0, frame=0; digit 1 is first enabled 4 cycles later.
REQ-038 With REFRESH_DIV=1, load 16'hFEDC -> digit cycles C,D,E,F on consecutive cycles; frame high every 4th cycle.

Source files
------------

// File: rtl/sseg_scan.sv
// Four-digit seven-segment scanner: prescaled digit rotation, held display data,
// leading-zero blanking and a registered end-of-frame pulse.
module sseg_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [15:0]     r_val;
  logic [3:0]      r_dp;
  logic            r_blz;
  logic            r_frame;

  logic            w_tick;
  logic [3:0][3:0] w_nib;
  logic [4:0]      w_upper_zero;
  logic            w_blank;

  assign w_tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_val   <= '0;
      r_dp    <= '0;
      r_blz   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
      r_frame <= w_tick && (r_idx == 2'd3);
      // Load only touches the held data, so scan timing is never disturbed.
      if (load) begin
        r_val <= value;
        r_dp  <= dp_in;
        r_blz <= blank_lz;
      end
    end
  end

  assign w_nib = r_val;

  // w_upper_zero[k]: every held nibble at position >= k is zero.
  assign w_upper_zero[4] = 1'b1;
  for (genvar k = 0; k < 4; k++) begin : g_zero
    assign w_upper_zero[k] = (w_nib[k] == 4'h0) && w_upper_zero[k+1];
  end

  assign w_blank = r_blz && (r_idx != 2'd0) && w_upper_zero[r_idx];

  assign digit = w_nib[r_idx];
  assign an    = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
  assign dp    = w_blank | ~r_dp[r_idx];
  assign frame = r_frame;
endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: two instances (dwell 4 and dwell 1) share one stimulus and are
// compared each cycle against an edge-counting reference model.
module tb_sseg_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit4, an4, digit1, an1;
  logic        dp4, frame4, dp1, frame1;

  int tests = 0;
  int fails = 0;

  // Reference state: edges since last reset and the held display data.
  int          m_n = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic        m_blz = 1'b0;

  always #5 clk = ~clk;

  sseg_scan #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .digit(digit4), .an(an4), .dp(dp4), .frame(frame4));

  sseg_scan #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .digit(digit1), .an(an1), .dp(dp1), .frame(frame1));

  // Expected {digit, an, dp, frame} for a given dwell.
  function automatic logic [9:0] model(input int div);
    int          idx;
    logic [15:0] upper;
    logic        blank;
    logic [3:0]  d, a;
    logic        p, f;
    idx   = (m_n / div) % 4;
    upper = m_val >> (idx * 4);
    blank = m_blz && (idx > 0) && (upper == 16'h0);
    d     = m_val[idx*4 +: 4];
    a     = blank ? 4'b1111 : 4'(~(1 << idx));
    p     = blank ? 1'b1 : ~m_dp[idx];
    f     = (m_n > 0) && (m_n % (4 * div) == 0);
    return {d, a, p, f};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, m_n, got, exp);
    end
  endtask

  task automatic check_all();
    logic [9:0] e4, e1;
    e4 = model(4);
    e1 = model(1);
    chk("d4.digit", digit4, e4[9:6]);
    chk("d4.an",    an4,    e4[5:2]);
    chk("d4.dp",    {3'b0, dp4},    {3'b0, e4[1]});
    chk("d4.frame", {3'b0, frame4}, {3'b0, e4[0]});
    chk("d1.digit", digit1, e1[9:6]);
    chk("d1.an",    an1,    e1[5:2]);
    chk("d1.dp",    {3'b0, dp1},    {3'b0, e1[1]});
    chk("d1.frame", {3'b0, frame1}, {3'b0, e1[0]});
  endtask

  // Apply inputs, take one edge, update the model, check on the falling edge.
  task automatic cyc(input logic rst, input logic ld, input logic [15:0] v,
                     input logic [3:0] d, input logic b);
    rst_n = rst; load = ld; value = v; dp_in = d; blank_lz = b;
    @(posedge clk);
    if (!rst) begin
      m_n = 0; m_val = '0; m_dp = '0; m_blz = 1'b0;
    end else begin
      m_n++;
      if (ld) begin m_val = v; m_dp = d; m_blz = b; end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 16'(($urandom)), 4'($urandom), 1'($urandom));
  endtask

  initial begin
    // Reset, including a load that coincides with reset and must be dropped.
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'hFFFF, 4'hF, 1'b1);
    chk("rst.an", an4, 4'b1110);
    chk("rst.digit", digit4, 4'h0);

    // Plain scan of 1234.
    cyc(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    idle(40);

    // Leading-zero blanking.
    cyc(1'b1, 1'b1, 16'h0007, 4'h0, 1'b1);
    idle(20);
    cyc(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    idle(20);
    cyc(1'b1, 1'b1, 16'h1020, 4'b0100, 1'b1);
    idle(20);

    // Load on the edge that moves idx 1->2 in the dwell-4 instance.
    for (int i = 0; i < 32 && (m_n % 16) != 7; i++) idle(1);
    cyc(1'b1, 1'b1, 16'hABCD, 4'h0, 1'b0);
    chk("tick_load.digit", digit4, 4'hB);
    chk("tick_load.an", an4, 4'b1011);
    idle(6);

    // One-cycle reset mid-frame at idx 2.
    for (int i = 0; i < 32 && (m_n % 16) != 9; i++) idle(1);
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("midrst.an", an4, 4'b1110);
    chk("midrst.frame", {3'b0, frame4}, 4'h0);
    idle(3);
    chk("midrst.dwell", an4, 4'b1110);
    idle(1);
    chk("midrst.next", an4, 4'b1101);

    // Dwell-1 instance rotates every cycle.
    cyc(1'b1, 1'b1, 16'hFEDC, 4'h0, 1'b0);
    idle(12);

    // Randomized traffic with occasional reset and leading-zero values.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0), v,
          4'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
